// File: rtl/dsp48_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dsp48_pkg                                                            |
// | OPMODE encodings, sequencer states and default slice timing.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dsp48_pkg;

   // Pre-adder bypassed, post-adder add, CARRYIN=0 in all three encodings.
   localparam logic [7:0] OPM_FIRST = 8'b0000_0001;   // X=M, Z=0
   localparam logic [7:0] OPM_ACC   = 8'b0000_1001;   // X=M, Z=P
   localparam logic [7:0] OPM_HOLD  = 8'b0000_1000;   // X=0, Z=P

   localparam int DSP_LAT_DEF  = 3;
   localparam int OPM_SKEW_DEF = 1;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CLR   = 3'd1;
   localparam logic [2:0] ST_RUN   = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      CLR   = ST_CLR,
      RUN   = ST_RUN,
      DRAIN = ST_DRAIN,
      DONE  = ST_DONE
   } state_t;

endpackage
`default_nettype wire

// File: rtl/dsp48_mac_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dsp48_mac_sequencer_if                                               |
// | Job, operand stream, result stream and slice pins of the sequencer.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface dsp48_mac_sequencer_if #(
   parameter int LEN_W = 8
) ();
   logic                start;
   logic [LEN_W-1:0]    len;
   logic                busy;
   logic                in_valid;
   logic                in_ready;
   logic signed [17:0]  in_a;
   logic signed [17:0]  in_b;
   logic [17:0]         dsp_a;
   logic [17:0]         dsp_b;
   logic [7:0]          dsp_opmode;
   logic                dsp_ce;
   logic                dsp_rst;
   logic [47:0]         dsp_p;
   logic                res_valid;
   logic                res_ready;
   logic [47:0]         res_data;

   modport master (
      output start, len, in_valid, in_a, in_b, res_ready, dsp_p,
      input  busy, in_ready, res_valid, res_data,
             dsp_a, dsp_b, dsp_opmode, dsp_ce, dsp_rst
   );

   modport slave (
      input  start, len, in_valid, in_a, in_b, res_ready, dsp_p,
      output busy, in_ready, res_valid, res_data,
             dsp_a, dsp_b, dsp_opmode, dsp_ce, dsp_rst
   );
endinterface
`default_nettype wire

// File: rtl/dsp48_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dsp48_delay_line                                                     |
// | DEPTH x WIDTH enabled shift register with fill value; DEPTH=0 wires. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dsp48_delay_line #(
   parameter int               DEPTH = 1,
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] FILL  = '0
) (
   input  wire              clk,
   input  wire              rst,
   input  wire              en,
   input  wire              clr,
   input  wire  [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_pass
         assign dout = din;
      end else begin : g_shift
         logic [WIDTH-1:0] r_sr [DEPTH];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) r_sr[i] <= FILL;
            end else if (clr) begin
               for (int i = 0; i < DEPTH; i++) r_sr[i] <= FILL;
            end else if (en) begin
               r_sr[0] <= din;
               for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
            end
         end

         assign dout = r_sr[DEPTH-1];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/dsp48_mac_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dsp48_mac_sequencer                                                  |
// | Streams a dot-product job through one DSP48A1 and returns P.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dsp48_mac_sequencer
   import dsp48_pkg::*;
#(
   parameter int LEN_W    = 8,
   parameter int DSP_LAT  = DSP_LAT_DEF,
   parameter int OPM_SKEW = OPM_SKEW_DEF
) (
   input wire clk,
   input wire rst,
   dsp48_mac_sequencer_if.slave bus
);

   localparam logic [7:0] c_DRAIN_LOAD = 8'(DSP_LAT + OPM_SKEW - 1);

   state_t           r_state, w_next;
   logic [LEN_W-1:0] r_len, r_cnt, w_cnt_nxt;
   logic [7:0]       r_drain;
   logic [47:0]      r_res;
   logic             w_in_ready, w_ce, w_clr, w_accept, w_last;
   logic [7:0]       w_opm_in, w_opm_out, w_opmode;
   logic [17:0]      w_a, w_b;

   assign w_cnt_nxt = r_cnt + LEN_W'(1);
   assign w_accept  = bus.in_valid && w_in_ready;
   assign w_last    = w_accept && (w_cnt_nxt == r_len);
   assign w_opm_in  = (r_state != RUN) ? OPM_HOLD :
                      (r_cnt == '0)    ? OPM_FIRST : OPM_ACC;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_next = (bus.len != '0) ? CLR : DONE;
         CLR:     w_next = RUN;
         RUN:     if (w_last) w_next = DRAIN;
         DRAIN:   if (r_drain == 8'd0) w_next = DONE;
         DONE:    if (bus.res_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // A bubble drops CE, freezing the slice and the OPMODE skew together.
   always_comb begin
      w_in_ready = 1'b0;
      w_ce       = 1'b0;
      w_clr      = 1'b0;
      w_a        = '0;
      w_b        = '0;
      case (r_state)
         CLR:   w_clr = 1'b1;
         RUN: begin
            w_in_ready = (r_cnt != r_len);
            w_ce       = bus.in_valid && w_in_ready;
            w_a        = bus.in_a;
            w_b        = bus.in_b;
         end
         DRAIN: w_ce = 1'b1;
         default: ;
      endcase
      w_opmode = (r_state == IDLE) ? 8'h00 : w_opm_out;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_len   <= '0;
         r_cnt   <= '0;
         r_drain <= '0;
         r_res   <= '0;
      end else begin
         case (r_state)
            IDLE: if (bus.start) begin
               r_len <= bus.len;
               r_cnt <= '0;
               if (bus.len == '0) r_res <= '0;
            end
            RUN: if (w_accept) begin
               r_cnt   <= w_cnt_nxt;
               r_drain <= c_DRAIN_LOAD;
            end
            DRAIN: begin
               if (r_drain == 8'd0) r_res   <= bus.dsp_p;
               else                 r_drain <= r_drain - 8'd1;
            end
            default: ;
         endcase
      end
   end

   dsp48_delay_line #(
      .DEPTH (OPM_SKEW),
      .WIDTH (8),
      .FILL  (OPM_HOLD)
   ) u_opm_skew (
      .clk  (clk),
      .rst  (rst),
      .en   (w_ce),
      .clr  (w_clr),
      .din  (w_opm_in),
      .dout (w_opm_out)
   );

   assign bus.in_ready   = w_in_ready;
   assign bus.dsp_ce     = w_ce;
   assign bus.dsp_rst    = rst | w_clr;
   assign bus.dsp_a      = w_a;
   assign bus.dsp_b      = w_b;
   assign bus.dsp_opmode = w_opmode;
   assign bus.busy       = (r_state != IDLE);
   assign bus.res_valid  = (r_state == DONE);
   assign bus.res_data   = r_res;

endmodule
`default_nettype wire
